// File: rtl/axis_pkg.sv
// Shared definitions for the reference tracker: tracker FSM state encoding
// and the default values of the tracker parameters.
// Ports: none (package only).
package axis_pkg;

  localparam int POS_W_DEF    = 16;
  localparam int FILT_LEN_DEF = 4;
  localparam int REF_POL_DEF  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_DONE = 2'd2
  } trk_state_t;

endpackage

// File: rtl/ref_filter.sv
// Purpose: synchronise the raw Ref sensor, debounce it and flag active edges.
// Latency: RefEdge is high after the (FILT_LEN+2)th Clk edge of a stable new level.
// Backpressure: none; the sensor is sampled every cycle.
// Ports: Clk, RefDoneClr (async, active-high), Ref (raw sensor),
//        RefEdge (one-cycle pulse per filtered active edge).
module ref_filter #(
  parameter int FILT_LEN = 4,
  parameter int REF_POL  = 0
) (
  input  logic Clk,
  input  logic RefDoneClr,
  input  logic Ref,
  output logic RefEdge
);

  // Idle level is opposite the active edge target, so reset never looks
  // like an edge when the sensor is parked at rest.
  localparam logic IDLE_LVL = (REF_POL == 0) ? 1'b1 : 1'b0;
  localparam logic ACT_LVL  = ~IDLE_LVL;
  localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

  logic       sync1_q, sync2_q;
  logic       lvl_q, lvl_d;
  logic       edge_q, edge_d;
  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples disagreeing with the filtered level;
  // the level flips on the FILT_LEN-th one.
  always_comb begin
    lvl_d  = lvl_q;
    cnt_d  = cnt_q;
    edge_d = 1'b0;
    if (sync2_q == lvl_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d  = sync2_q;
      cnt_d  = 8'd0;
      edge_d = (sync2_q == ACT_LVL);
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or posedge RefDoneClr) begin
    if (RefDoneClr) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      lvl_q   <= IDLE_LVL;
      cnt_q   <= 8'd0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= Ref;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
    end
  end

  assign RefEdge = edge_q;

endmodule

// File: rtl/axis_ref_tracker.sv
// Purpose: axis position counter with reference (homing) search FSM.
// Latency: counter updates 1 cycle after Pls/PlsClr; DONE/load 1 cycle after RefEdge.
// Backpressure: none; every Pls strobe is accepted unless overridden.
// Ports: Clk, RefDoneClr (async, active-high), Ref, RefEn, RefPos, Pls, DirCmd,
//        PlsClr in; PosCnt, RefCapt, RefDone, Seeking, RefEdge out.
module axis_ref_tracker
  import axis_pkg::*;
#(
  parameter int POS_W    = POS_W_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int REF_POL  = REF_POL_DEF
) (
  input  logic             Clk,
  input  logic             RefDoneClr,
  input  logic             Ref,
  input  logic             RefEn,
  input  logic [POS_W-1:0] RefPos,
  input  logic             Pls,
  input  logic             DirCmd,
  input  logic             PlsClr,
  output logic [POS_W-1:0] PosCnt,
  output logic [POS_W-1:0] RefCapt,
  output logic             RefDone,
  output logic             Seeking,
  output logic             RefEdge
);

  trk_state_t       state_q;
  logic             seek_q, done_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] capt_q, capt_d;
  logic             ref_edge;
  logic             load;

  ref_filter #(
    .FILT_LEN (FILT_LEN),
    .REF_POL  (REF_POL)
  ) u_ref_filter (
    .Clk        (Clk),
    .RefDoneClr (RefDoneClr),
    .Ref        (Ref),
    .RefEdge    (ref_edge)
  );

  // Edges seen outside SEEK are reported but never load the counter.
  assign load = (state_q == ST_SEEK) && ref_edge;

  always_comb begin
    pos_d  = pos_q;
    capt_d = capt_q;
    if (load) begin
      capt_d = pos_q;
      pos_d  = RefPos;
    end else if (PlsClr) begin
      pos_d = '0;
    end else if (Pls) begin
      pos_d = DirCmd ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge RefDoneClr) begin
    if (RefDoneClr) begin
      pos_q  <= '0;
      capt_q <= '0;
    end else begin
      pos_q  <= pos_d;
      capt_q <= capt_d;
    end
  end

  // Seeking/RefDone are registered alongside the state so they track it exactly.
  always_ff @(posedge Clk or posedge RefDoneClr) begin
    if (RefDoneClr) begin
      state_q <= ST_IDLE;
      seek_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (RefEn) begin
            state_q <= ST_SEEK;
            seek_q  <= 1'b1;
          end
        end
        ST_SEEK: begin
          // An edge arriving with RefEn dropping still completes the search.
          if (ref_edge) begin
            state_q <= ST_DONE;
            seek_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!RefEn) begin
            state_q <= ST_IDLE;
            seek_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
          seek_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PosCnt  = pos_q;
  assign RefCapt = capt_q;
  assign RefDone = done_q;
  assign Seeking = seek_q;
  assign RefEdge = ref_edge;

endmodule

// File: tb/tb_axis_ref_tracker.sv
module tb_axis_ref_tracker;

  localparam int POS_W    = 16;
  localparam int FILT_LEN = 4;
  localparam int REF_POL  = 0;
  localparam bit IDLE     = (REF_POL == 0);

  logic              Clk = 1'b0;
  logic              RefDoneClr = 1'b1;
  logic              Ref = IDLE;
  logic              RefEn = 1'b0;
  logic [POS_W-1:0]  RefPos = '0;
  logic              Pls = 1'b0;
  logic              DirCmd = 1'b0;
  logic              PlsClr = 1'b0;
  logic [POS_W-1:0]  PosCnt, RefCapt;
  logic              RefDone, Seeking, RefEdge;

  axis_ref_tracker #(.POS_W(POS_W), .FILT_LEN(FILT_LEN), .REF_POL(REF_POL)) dut (
    .Clk(Clk), .RefDoneClr(RefDoneClr), .Ref(Ref), .RefEn(RefEn), .RefPos(RefPos),
    .Pls(Pls), .DirCmd(DirCmd), .PlsClr(PlsClr), .PosCnt(PosCnt), .RefCapt(RefCapt),
    .RefDone(RefDone), .Seeking(Seeking), .RefEdge(RefEdge)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] capt;
    bit done;
    bit seek;
    bit edg;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: raw Ref reaches the filter two edges late; the filtered
  // level flips once the last FILT_LEN samples all disagree with it.
  bit d1, d2, lvl;
  bit win[$];
  bit m_seek, m_done, m_edge;
  logic [POS_W-1:0] m_pos, m_capt;

  function automatic void model_reset();
    d1 = IDLE; d2 = IDLE; lvl = IDLE;
    win.delete();
    m_seek = 0; m_done = 0; m_edge = 0;
    m_pos = '0; m_capt = '0;
  endfunction

  function automatic void model_edge(input bit r, input bit en, input logic [POS_W-1:0] rp,
                                     input bit p, input bit dir, input bit clr);
    bit s, flip, new_edge, load;
    int n;
    s = d2; d2 = d1; d1 = r;
    win.push_back(s);
    if (win.size() > FILT_LEN) void'(win.pop_front());
    n = 0;
    foreach (win[i]) if (win[i] != lvl) n++;
    flip = (win.size() == FILT_LEN) && (n == FILT_LEN);
    new_edge = 0;
    if (flip) begin
      lvl = ~lvl;
      new_edge = (lvl == bit'(REF_POL));
    end
    load = m_seek && m_edge;
    if (load) begin
      m_capt = m_pos;
      m_pos  = rp;
    end else if (clr) m_pos = '0;
    else if (p) m_pos = dir ? m_pos + 1'b1 : m_pos - 1'b1;
    if (load) begin
      m_seek = 0; m_done = 1;
    end else if (m_seek && !en) m_seek = 0;
    else if (!m_seek && !m_done && en) m_seek = 1;
    m_edge = new_edge;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit en, input logic [POS_W-1:0] rp,
                      input bit p, input bit dir, input bit clr);
    exp_t e;
    @(negedge Clk);
    Ref = r; RefEn = en; RefPos = rp; Pls = p; DirCmd = dir; PlsClr = clr;
    model_edge(r, en, rp, p, dir, clr);
    e.pos = m_pos; e.capt = m_capt; e.done = m_done; e.seek = m_seek; e.edg = m_edge;
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pos"}, 32'(PosCnt), 0);
    chk({tag, "_capt"}, 32'(RefCapt), 0);
    chk({tag, "_flags"}, {29'd0, RefDone, Seeking, RefEdge}, 0);
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, releases before the next negedge.
  task automatic do_reset();
    @(negedge Clk);
    #2 RefDoneClr = 1'b1;
    #1 chk_zero("rst_async");
    model_reset();
    @(posedge Clk);
    #1 RefDoneClr = 1'b0;
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_pos",  32'(PosCnt),  32'(e.pos));
        chk("sb_capt", 32'(RefCapt), 32'(e.capt));
        chk("sb_done", 32'(RefDone), 32'(e.done));
        chk("sb_seek", 32'(Seeking), 32'(e.seek));
        chk("sb_edge", 32'(RefEdge), 32'(e.edg));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first, cnt, hold;
    bit r, en;
    model_reset();
    @(posedge Clk);
    #1 chk_zero("rst_init");
    @(negedge Clk);
    RefDoneClr = 1'b0;

    // Count and wrap
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0, 0);
    after_edge(); chk("wrap_down", 32'(PosCnt), 32'hFFFD);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 1, 0);
    after_edge(); chk("wrap_up", 32'(PosCnt), 32'h0000);

    // Homing
    step(1, 1, 16'h0200, 0, 1, 0);
    for (int i = 0; i < 100; i++) step(1, 1, 16'h0200, 1, 1, 0);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 16'h0200, 0, 1, 0);
      after_edge();
      if (RefEdge && first == 0) first = i;
    end
    chk("home_edge_at", 32'(first), FILT_LEN + 2);
    chk("home_capt", 32'(RefCapt), 100);
    chk("home_pos", 32'(PosCnt), 32'h0200);
    chk("home_done", 32'(RefDone), 1);
    chk("home_seek", 32'(Seeking), 0);

    // Glitch shorter than the filter
    do_reset();
    step(1, 1, 16'h0300, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 16'h0300, 1, 1, 0);
    cnt = 0;
    for (int i = 0; i < 13; i++) begin
      step(i >= 3, 1, 16'h0300, 0, 1, 0);
      after_edge();
      if (RefEdge) cnt++;
    end
    chk("glitch_edges", 32'(cnt), 0);
    chk("glitch_pos", 32'(PosCnt), 10);
    chk("glitch_done", 32'(RefDone), 0);

    // Priority: load beats PlsClr beats Pls
    do_reset();
    step(1, 1, 16'h1234, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 16'h1234, 1, 1, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, 16'h1234, i == 7, 1, i == 7);
    after_edge(); chk("prio_load", 32'(PosCnt), 32'h1234);
    step(0, 1, 16'h1234, 1, 1, 1);
    after_edge(); chk("prio_clr", 32'(PosCnt), 0);
    chk("prio_capt_kept", 32'(RefCapt), 7);

    // Unarmed edge
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0055, 1, 1, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 16'h0055, 0, 1, 0);
      after_edge();
      if (RefEdge) cnt++;
    end
    chk("unarmed_edges", 32'(cnt), 1);
    chk("unarmed_pos", 32'(PosCnt), 5);
    chk("unarmed_state", {30'd0, RefDone, Seeking}, 0);

    // Reset mid-search, then re-arm
    do_reset();
    step(1, 1, '0, 0, 1, 0);
    for (int i = 0; i < 50; i++) step(1, 1, '0, 1, 1, 0);
    after_edge(); chk("mid_pos", 32'(PosCnt), 50);
    do_reset();
    step(1, 1, '0, 0, 1, 0);
    after_edge(); chk("rearm_seek", 32'(Seeking), 1);

    // RefEn falling with the edge still completes
    do_reset();
    step(1, 1, 16'h0777, 0, 1, 0);
    for (int i = 1; i <= 8; i++) step(0, i < 7, 16'h0777, 0, 1, 0);
    after_edge(); chk("en_drop_done", 32'(RefDone), 1);

    // Randomised traffic against the model
    do_reset();
    r = IDLE; hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        r = ~r;
        hold = $urandom_range(1, 9);
      end
      hold--;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      step(r, en, POS_W'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end
    after_edge();
    #1 chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
